// File: rtl/neureka_tcdm_split_reassembly_pkg.sv
// Shared constants and types for the wide-to-narrow TCDM splitter.
package neureka_tcdm_split_reassembly_pkg;

    localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 128;
    localparam int unsigned NEUREKA_SPLIT_DEPTH       = 2;
    localparam int unsigned NEUREKA_SPLIT_STRIDE      = 4;
    localparam int unsigned NEUREKA_SPLIT_MP          = NEUREKA_MEM_BANDWIDTH_EXT / 32;

    typedef logic [NEUREKA_SPLIT_MP-1:0] neureka_lane_mask_t;

endpackage

// File: rtl/neureka_tcdm_split_reassembly_lane_fifo.sv
// Small registered FIFO (no fall-through) used for per-lane response data and skip masks.
module neureka_tcdm_lane_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop frees the slot a same-cycle push needs when full.
    always_comb begin
        do_pop  = pop & (count != '0);
        do_push = push & ((count != CW'(DEPTH)) | do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= next_ptr(wptr);
            end
            if (do_pop) rptr <= next_ptr(rptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/neureka_tcdm_split_reassembly.sv
// Splits a wide TCDM request into 32-bit narrow ports and reassembles in-order wide responses.
module neureka_tcdm_split_reassembly
    import neureka_tcdm_split_reassembly_pkg::*;
#(
    parameter int unsigned BW         = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int unsigned DEPTH      = NEUREKA_SPLIT_DEPTH,
    parameter int unsigned STRIDE     = NEUREKA_SPLIT_STRIDE,
    parameter bit          SKIP_EMPTY = 1'b1,
    localparam int unsigned MP        = BW / 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 wide_req_i,
    output logic                 wide_gnt_o,
    input  logic [31:0]          wide_add_i,
    input  logic                 wide_wen_i,
    input  logic [BW/8-1:0]      wide_be_i,
    input  logic [BW-1:0]        wide_data_i,
    output logic [BW-1:0]        wide_r_data_o,
    output logic                 wide_r_valid_o,
    output logic [MP-1:0]        tcdm_req_o,
    input  logic [MP-1:0]        tcdm_gnt_i,
    output logic [MP-1:0][31:0]  tcdm_add_o,
    output logic [MP-1:0]        tcdm_wen_o,
    output logic [MP-1:0][3:0]   tcdm_be_o,
    output logic [MP-1:0][31:0]  tcdm_data_o,
    input  logic [MP-1:0][31:0]  tcdm_r_data_i,
    input  logic [MP-1:0]        tcdm_r_valid_i
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [MP-1:0]       skip;
    logic [MP-1:0]       done_q;
    logic [MP-1:0]       lane_ok;
    logic [MP-1:0]       head_skip;
    logic [MP-1:0]       lane_empty;
    logic [MP-1:0]       lane_full;
    logic [MP-1:0]       lane_pop;
    logic [MP-1:0][31:0] lane_rdata;
    logic [CW-1:0]       txn_cnt;
    logic                not_full;
    logic                txn_empty;
    logic                txn_full;

    // Lane fan-out of the wide request fields.
    always_comb begin
        for (int ii = 0; ii < int'(MP); ii++) begin
            tcdm_add_o[ii]  = wide_add_i + 32'(ii) * 32'(STRIDE);
            tcdm_wen_o[ii]  = wide_wen_i;
            tcdm_be_o[ii]   = wide_be_i[4*ii +: 4];
            tcdm_data_o[ii] = wide_data_i[32*ii +: 32];
            skip[ii]        = SKIP_EMPTY && (wide_be_i[4*ii +: 4] == 4'h0);
        end
    end

    // clear_i masks every handshake so nothing is half-accepted in the flush cycle.
    assign not_full       = (txn_cnt < CW'(DEPTH));
    assign tcdm_req_o     = {MP{wide_req_i & not_full & ~clear_i}} & ~done_q & ~skip;
    assign lane_ok        = done_q | skip | tcdm_gnt_i;
    assign wide_gnt_o     = wide_req_i & not_full & ~clear_i & (&lane_ok);
    assign wide_r_valid_o = ~clear_i & ~txn_empty & (&(head_skip | ~lane_empty));
    assign lane_pop       = {MP{wide_r_valid_o}} & ~head_skip;

    always_comb begin
        for (int ii = 0; ii < int'(MP); ii++) begin
            wide_r_data_o[32*ii +: 32] = lane_pop[ii] ? lane_rdata[ii] : 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= '0;
        end else if (clear_i || wide_gnt_o) begin
            done_q <= '0;
        end else begin
            done_q <= done_q | (tcdm_req_o & tcdm_gnt_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txn_cnt <= '0;
        end else if (clear_i) begin
            txn_cnt <= '0;
        end else if (wide_gnt_o && !wide_r_valid_o) begin
            txn_cnt <= txn_cnt + CW'(1);
        end else if (!wide_gnt_o && wide_r_valid_o) begin
            txn_cnt <= txn_cnt - CW'(1);
        end
    end

    neureka_tcdm_lane_fifo #(
        .WIDTH (MP),
        .DEPTH (DEPTH)
    ) i_txn_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (clear_i),
        .push  (wide_gnt_o),
        .wdata (skip),
        .pop   (wide_r_valid_o),
        .rdata (head_skip),
        .empty (txn_empty),
        .full  (txn_full)
    );

    for (genvar ii = 0; ii < int'(MP); ii++) begin : gen_lane
        neureka_tcdm_lane_fifo #(
            .WIDTH (32),
            .DEPTH (DEPTH)
        ) i_lane_fifo (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .clear (clear_i),
            .push  (tcdm_r_valid_i[ii]),
            .wdata (tcdm_r_data_i[ii]),
            .pop   (lane_pop[ii]),
            .rdata (lane_rdata[ii]),
            .empty (lane_empty[ii]),
            .full  (lane_full[ii])
        );

        a_lane_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
            tcdm_r_valid_i[ii] |-> (!lane_full[ii] || lane_pop[ii]));
    end

    a_txn_cnt_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        txn_full == (txn_cnt == CW'(DEPTH)));

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        (wide_req_i && !wide_gnt_o) |=> (!wide_req_i || ($stable(wide_add_i) && $stable(wide_be_i)
            && $stable(wide_wen_i) && $stable(wide_data_i))));

endmodule

// File: tb/tb_neureka_tcdm_split_reassembly.sv
// Directed bench for the TCDM splitter: BW=128, MP=4, DEPTH=2, SKIP_EMPTY=1.
module tb_neureka_tcdm_split_reassembly;
    import neureka_tcdm_split_reassembly_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clear;
    logic                wide_req;
    logic                wide_gnt;
    logic [31:0]         wide_add;
    logic                wide_wen;
    logic [15:0]         wide_be;
    logic [127:0]        wide_data;
    logic [127:0]        wide_r_data;
    logic                wide_r_valid;
    neureka_lane_mask_t  tcdm_req;
    neureka_lane_mask_t  tcdm_gnt;
    logic [3:0][31:0]    tcdm_add;
    neureka_lane_mask_t  tcdm_wen;
    logic [3:0][3:0]     tcdm_be;
    logic [3:0][31:0]    tcdm_data;
    logic [3:0][31:0]    tcdm_r_data;
    neureka_lane_mask_t  tcdm_r_valid;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] D1  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] D2  = 128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D;
    localparam logic [127:0] D4A = 128'h4A034A03_4A024A02_4A014A01_4A004A00;
    localparam logic [127:0] D4B = 128'h4B034B03_4B024B02_4B014B01_4B004B00;
    localparam logic [127:0] D4C = 128'h4C034C03_4C024C02_4C014C01_4C004C00;
    localparam logic [127:0] D4D = 128'h4D034D03_4D024D02_4D014D01_4D004D00;
    localparam logic [127:0] D5A = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] D5B = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [127:0] D6C = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [127:0] D6D = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;

    always #5 clk = ~clk;

    neureka_tcdm_split_reassembly #(
        .BW         (128),
        .DEPTH      (2),
        .STRIDE     (4),
        .SKIP_EMPTY (1'b1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .wide_req_i     (wide_req),
        .wide_gnt_o     (wide_gnt),
        .wide_add_i     (wide_add),
        .wide_wen_i     (wide_wen),
        .wide_be_i      (wide_be),
        .wide_data_i    (wide_data),
        .wide_r_data_o  (wide_r_data),
        .wide_r_valid_o (wide_r_valid),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear        = 1'b0;
        wide_req     = 1'b0;
        wide_add     = 32'h0;
        wide_wen     = 1'b1;
        wide_be      = 16'hFFFF;
        wide_data    = '0;
        tcdm_gnt     = '0;
        tcdm_r_data  = '0;
        tcdm_r_valid = '0;
    endtask

    task automatic read_req(input logic [31:0] addr, input logic [3:0] gnt);
        wide_req = 1'b1;
        wide_add = addr;
        wide_wen = 1'b1;
        wide_be  = 16'hFFFF;
        tcdm_gnt = gnt;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_gnt", 128'(wide_gnt), 128'h0);
        check_eq("rst_rvalid", 128'(wide_r_valid), 128'h0);
        check_eq("rst_rdata", wide_r_data, 128'h0);
        check_eq("rst_req", 128'(tcdm_req), 128'h0);
        rst_n = 1'b1;
        cyc();

        // 1: all grants in the issue cycle
        read_req(32'h100, 4'hF);
        @(negedge clk);
        check_eq("t1_gnt", 128'(wide_gnt), 128'h1);
        check_eq("t1_req", 128'(tcdm_req), 128'hF);
        check_eq("t1_add", 128'(tcdm_add), 128'h0000010C_00000108_00000104_00000100);
        check_eq("t1_wen", 128'(tcdm_wen), 128'hF);
        cyc();
        idle_inputs();
        tcdm_r_valid = 4'hF;
        tcdm_r_data  = D1;
        @(negedge clk);
        check_eq("t1_rv_early", 128'(wide_r_valid), 128'h0);
        cyc();
        tcdm_r_valid = '0;
        @(negedge clk);
        check_eq("t1_rv", 128'(wide_r_valid), 128'h1);
        check_eq("t1_rdata", wide_r_data, D1);
        cyc();
        @(negedge clk);
        check_eq("t1_rv_after", 128'(wide_r_valid), 128'h0);
        cyc();

        // 2: staggered grants
        read_req(32'h200, 4'b0001);
        @(negedge clk);
        check_eq("t2_req0", 128'(tcdm_req), 128'hF);
        check_eq("t2_gnt0", 128'(wide_gnt), 128'h0);
        cyc();
        tcdm_gnt = 4'b0110;
        @(negedge clk);
        check_eq("t2_req1", 128'(tcdm_req), 128'hE);
        check_eq("t2_gnt1", 128'(wide_gnt), 128'h0);
        cyc();
        tcdm_gnt = 4'b0000;
        @(negedge clk);
        check_eq("t2_req2", 128'(tcdm_req), 128'h8);
        check_eq("t2_gnt2", 128'(wide_gnt), 128'h0);
        cyc();
        tcdm_gnt = 4'b1000;
        @(negedge clk);
        check_eq("t2_req3", 128'(tcdm_req), 128'h8);
        check_eq("t2_gnt3", 128'(wide_gnt), 128'h1);
        cyc();
        idle_inputs();
        tcdm_r_valid = 4'b0001;
        tcdm_r_data  = D2;
        @(negedge clk);
        check_eq("t2_rv_a", 128'(wide_r_valid), 128'h0);
        cyc();
        tcdm_r_valid = 4'b1110;
        @(negedge clk);
        check_eq("t2_rv_b", 128'(wide_r_valid), 128'h0);
        cyc();
        tcdm_r_valid = '0;
        @(negedge clk);
        check_eq("t2_rv", 128'(wide_r_valid), 128'h1);
        check_eq("t2_rdata", wide_r_data, D2);
        cyc();
        @(negedge clk);
        check_eq("t2_rv_after", 128'(wide_r_valid), 128'h0);
        cyc();

        // 3: skipped lanes, write to lane 1 only
        wide_req  = 1'b1;
        wide_add  = 32'h300;
        wide_wen  = 1'b0;
        wide_be   = 16'h00F0;
        wide_data = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
        tcdm_gnt  = 4'b0010;
        @(negedge clk);
        check_eq("t3_req", 128'(tcdm_req), 128'h2);
        check_eq("t3_gnt", 128'(wide_gnt), 128'h1);
        check_eq("t3_be", 128'(tcdm_be), 128'h00F0);
        check_eq("t3_wen", 128'(tcdm_wen), 128'h0);
        check_eq("t3_data", 128'(tcdm_data), 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000);
        cyc();
        idle_inputs();
        tcdm_r_valid = 4'b0010;
        tcdm_r_data  = 128'hFFFFFFFF_FFFFFFFF_12345678_FFFFFFFF;
        @(negedge clk);
        check_eq("t3_rv_early", 128'(wide_r_valid), 128'h0);
        cyc();
        tcdm_r_valid = '0;
        @(negedge clk);
        check_eq("t3_rv", 128'(wide_r_valid), 128'h1);
        check_eq("t3_rdata", wide_r_data, 128'h00000000_00000000_12345678_00000000);
        cyc();

        // 4: back-to-back reads against a full transaction budget
        read_req(32'h400, 4'hF);
        @(negedge clk);
        check_eq("t4_gnt_a", 128'(wide_gnt), 128'h1);
        cyc();
        wide_add = 32'h410;
        @(negedge clk);
        check_eq("t4_gnt_b", 128'(wide_gnt), 128'h1);
        cyc();
        wide_add = 32'h420;
        @(negedge clk);
        check_eq("t4_req_full", 128'(tcdm_req), 128'h0);
        check_eq("t4_gnt_full", 128'(wide_gnt), 128'h0);
        cyc();
        tcdm_r_valid = 4'hF;
        tcdm_r_data  = D4A;
        @(negedge clk);
        check_eq("t4_req_full2", 128'(tcdm_req), 128'h0);
        check_eq("t4_rv_early", 128'(wide_r_valid), 128'h0);
        cyc();
        tcdm_r_data = D4B;
        @(negedge clk);
        check_eq("t4_rv_a", 128'(wide_r_valid), 128'h1);
        check_eq("t4_rdata_a", wide_r_data, D4A);
        check_eq("t4_req_full3", 128'(tcdm_req), 128'h0);
        cyc();
        tcdm_r_valid = '0;
        @(negedge clk);
        check_eq("t4_req_c", 128'(tcdm_req), 128'hF);
        check_eq("t4_gnt_c", 128'(wide_gnt), 128'h1);
        check_eq("t4_rv_b", 128'(wide_r_valid), 128'h1);
        check_eq("t4_rdata_b", wide_r_data, D4B);
        cyc();
        wide_add = 32'h430;
        @(negedge clk);
        check_eq("t4_gnt_d", 128'(wide_gnt), 128'h1);
        check_eq("t4_rv_none", 128'(wide_r_valid), 128'h0);
        cyc();
        wide_add     = 32'h440;
        tcdm_r_valid = 4'hF;
        tcdm_r_data  = D4C;
        @(negedge clk);
        check_eq("t4_req_full4", 128'(tcdm_req), 128'h0);
        check_eq("t4_gnt_full4", 128'(wide_gnt), 128'h0);
        cyc();
        tcdm_r_data = D4D;
        @(negedge clk);
        check_eq("t4_rv_c", 128'(wide_r_valid), 128'h1);
        check_eq("t4_rdata_c", wide_r_data, D4C);
        check_eq("t4_req_full5", 128'(tcdm_req), 128'h0);
        cyc();
        tcdm_r_valid = '0;
        wide_req     = 1'b0;
        @(negedge clk);
        check_eq("t4_rv_d", 128'(wide_r_valid), 128'h1);
        check_eq("t4_rdata_d", wide_r_data, D4D);
        cyc();
        idle_inputs();
        @(negedge clk);
        check_eq("t4_rv_after", 128'(wide_r_valid), 128'h0);
        cyc();

        // 5: lane 2 responses trail the others by 5 cycles
        read_req(32'h500, 4'hF);
        @(negedge clk);
        check_eq("t5_gnt_a", 128'(wide_gnt), 128'h1);
        cyc();
        wide_add     = 32'h510;
        tcdm_r_valid = 4'b1011;
        tcdm_r_data  = D5A;
        @(negedge clk);
        check_eq("t5_gnt_b", 128'(wide_gnt), 128'h1);
        cyc();
        idle_inputs();
        tcdm_r_valid = 4'b1011;
        tcdm_r_data  = D5B;
        @(negedge clk);
        check_eq("t5_rv_w0", 128'(wide_r_valid), 128'h0);
        cyc();
        tcdm_r_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t5_rv_wait", 128'(wide_r_valid), 128'h0);
            cyc();
        end
        tcdm_r_valid = 4'b0100;
        tcdm_r_data  = D5A;
        @(negedge clk);
        check_eq("t5_rv_w4", 128'(wide_r_valid), 128'h0);
        cyc();
        tcdm_r_data = D5B;
        @(negedge clk);
        check_eq("t5_rv_a", 128'(wide_r_valid), 128'h1);
        check_eq("t5_rdata_a", wide_r_data, D5A);
        cyc();
        tcdm_r_valid = '0;
        @(negedge clk);
        check_eq("t5_rv_b", 128'(wide_r_valid), 128'h1);
        check_eq("t5_rdata_b", wide_r_data, D5B);
        cyc();
        @(negedge clk);
        check_eq("t5_rv_after", 128'(wide_r_valid), 128'h0);
        cyc();

        // 6: clear with a buffered response and a half-granted request
        read_req(32'h600, 4'hF);
        @(negedge clk);
        check_eq("t6_gnt_c", 128'(wide_gnt), 128'h1);
        cyc();
        read_req(32'h700, 4'b0011);
        tcdm_r_valid = 4'hF;
        tcdm_r_data  = D6C;
        @(negedge clk);
        check_eq("t6_gnt_part", 128'(wide_gnt), 128'h0);
        cyc();
        clear        = 1'b1;
        tcdm_gnt     = '0;
        @(negedge clk);
        check_eq("t6_rv_clear", 128'(wide_r_valid), 128'h0);
        cyc();
        clear        = 1'b0;
        tcdm_r_valid = '0;
        tcdm_gnt     = 4'hF;
        @(negedge clk);
        check_eq("t6_rv_post", 128'(wide_r_valid), 128'h0);
        check_eq("t6_req_all", 128'(tcdm_req), 128'hF);
        check_eq("t6_gnt_d", 128'(wide_gnt), 128'h1);
        cyc();
        idle_inputs();
        tcdm_r_valid = 4'hF;
        tcdm_r_data  = D6D;
        @(negedge clk);
        check_eq("t6_rv_early", 128'(wide_r_valid), 128'h0);
        cyc();
        tcdm_r_valid = '0;
        @(negedge clk);
        check_eq("t6_rv_d", 128'(wide_r_valid), 128'h1);
        check_eq("t6_rdata_d", wide_r_data, D6D);
        cyc();
        @(negedge clk);
        check_eq("t6_rv_after", 128'(wide_r_valid), 128'h0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
